// File: rtl/cpu_ex_result_buffer.sv
// Two-entry result buffer between the ALU and write-back.
// HEAD drives the write-back port. SKID holds a second, younger entry.
// in_ready is taken from registered occupancy only, so a write-back stall
// never reaches the execute stage combinationally. The buffer also holds
// the committed ZCVN flag register and forwards buffered results to operand fetch.
module cpu_ex_result_buffer #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [3:0]        in_flag,
  input  logic [REG_AW-1:0] in_dst,
  input  logic              in_we,
  input  logic              in_setf,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [REG_AW-1:0] out_dst,
  output logic              out_we,
  output logic [3:0]        flag_q,
  input  logic [REG_AW-1:0] fwd_idx,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Handshake qualifiers. Flush overrides both directions.
  logic accept;
  logic pop;

  // Slot load controls, decoded from occupancy and handshakes
  logic head_load_in;
  logic head_load_skid;
  logic skid_load;

  // Slot contents. HEAD is the older entry and SKID is the younger one.
  logic [DATA_W-1:0] head_data;
  logic [REG_AW-1:0] head_dst;
  logic              head_we;
  logic [DATA_W-1:0] skid_data;
  logic [REG_AW-1:0] skid_dst;
  logic              skid_we;

  // Occupancy-derived slot validity
  logic head_vld;
  logic skid_vld;

  // Forwarding match terms
  logic head_match;
  logic skid_match;

  assign accept = in_valid & in_ready & ~flush;
  assign pop    = out_valid & out_ready & ~flush;

  // Occupancy state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next occupancy. Flush empties the buffer and drops any input in that cycle.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) state_nxt = ONE;
        end
        ONE: begin
          if (accept && !pop)      state_nxt = FULL;
          else if (!accept && pop) state_nxt = EMPTY;
          else                     state_nxt = ONE;
        end
        FULL: begin
          // in_ready is low while FULL, so only a pop can move the state
          if (pop) state_nxt = ONE;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Handshake outputs and slot load decode. in_ready depends only on state and rst.
  always_comb begin
    in_ready       = (state != FULL) & ~rst;
    out_valid      = (state != EMPTY);
    head_vld       = (state != EMPTY);
    skid_vld       = (state == FULL);
    head_load_in   = 1'b0;
    head_load_skid = 1'b0;
    skid_load      = 1'b0;
    unique case (state)
      EMPTY: begin
        head_load_in = accept;
      end
      ONE: begin
        // Input goes to HEAD when HEAD drains in the same cycle, otherwise to SKID
        head_load_in = accept & pop;
        skid_load    = accept & ~pop;
      end
      FULL: begin
        head_load_skid = pop;
      end
      default: begin
        head_load_in   = 1'b0;
        head_load_skid = 1'b0;
        skid_load      = 1'b0;
      end
    endcase
  end

  // HEAD slot: loads from the input or advances the SKID entry on a pop from FULL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_data <= '0;
      head_dst  <= '0;
      head_we   <= 1'b0;
    end else if (head_load_in) begin
      head_data <= in_data;
      head_dst  <= in_dst;
      head_we   <= in_we;
    end else if (head_load_skid) begin
      head_data <= skid_data;
      head_dst  <= skid_dst;
      head_we   <= skid_we;
    end
  end

  // SKID slot: captures the younger entry while HEAD is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_data <= '0;
      skid_dst  <= '0;
      skid_we   <= 1'b0;
    end else if (skid_load) begin
      skid_data <= in_data;
      skid_dst  <= in_dst;
      skid_we   <= in_we;
    end
  end

  // Architectural flags commit at acceptance in program order. Flush never rolls them back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q <= 4'b0000;
    end else if (accept && in_setf) begin
      flag_q <= in_flag;
    end
  end

  assign out_data = head_data;
  assign out_dst  = head_dst;
  assign out_we   = head_we;

  // Forwarding: the younger SKID entry takes priority over HEAD. Data is zero on a miss.
  always_comb begin
    head_match = head_vld & head_we & (head_dst == fwd_idx);
    skid_match = skid_vld & skid_we & (skid_dst == fwd_idx);
    fwd_hit    = head_match | skid_match;
    if (skid_match) begin
      fwd_data = skid_data;
    end else if (head_match) begin
      fwd_data = head_data;
    end else begin
      fwd_data = '0;
    end
  end

endmodule

// File: tb/tb_cpu_ex_result_buffer.sv
// Directed testbench for cpu_ex_result_buffer. Each scenario task drives
// inputs and compares outputs against hand-computed values 1 ns after the
// rising edge.
module tb_cpu_ex_result_buffer;

  localparam int DATA_W = 32;
  localparam int REG_AW = 4;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [3:0]        in_flag;
  logic [REG_AW-1:0] in_dst;
  logic              in_we;
  logic              in_setf;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [REG_AW-1:0] out_dst;
  logic              out_we;
  logic [3:0]        flag_q;
  logic [REG_AW-1:0] fwd_idx;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  int n_cmp;
  int n_err;

  cpu_ex_result_buffer #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_flag(in_flag), .in_dst(in_dst), .in_we(in_we), .in_setf(in_setf),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_dst(out_dst), .out_we(out_we),
    .flag_q(flag_q),
    .fwd_idx(fwd_idx), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [3:0] f,
                       input logic [REG_AW-1:0] dst, input logic we, input logic setf);
    in_valid = v; in_data = d; in_flag = f; in_dst = dst; in_we = we; in_setf = setf;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, 4'b0000, '0, 1'b0, 1'b0);
    flush = 1'b0; out_ready = 1'b0; fwd_idx = '0;
    tick(); tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    n_cmp++; if (flag_q !== 4'b0000) begin n_err++; $display("FAIL reset_flag_q got=%b want=0000", flag_q); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    n_cmp++; if (out_dst !== 4'd0 || out_we !== 1'b0) begin n_err++; $display("FAIL reset_out_dst_we got=%0d/%b want=0/0", out_dst, out_we); end
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_0005, 4'b0000, 4'd3, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, 4'b0000, '0, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_out_valid got=%b want=1", out_valid); end
    n_cmp++; if (out_data !== 32'h5) begin n_err++; $display("FAIL single_out_data got=%h want=5", out_data); end
    n_cmp++; if (out_dst !== 4'd3 || out_we !== 1'b1) begin n_err++; $display("FAIL single_dst_we got=%0d/%b want=3/1", out_dst, out_we); end
    n_cmp++; if (flag_q !== 4'b0000) begin n_err++; $display("FAIL single_flag_q got=%b want=0000", flag_q); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    drive(1'b1, 32'h11, 4'b0000, 4'd1, 1'b1, 1'b0);
    tick();
    n_cmp++; if (out_data !== 32'h11 || in_ready !== 1'b1) begin n_err++; $display("FAIL stall_one got=%h/%b want=11/1", out_data, in_ready); end
    drive(1'b1, 32'h22, 4'b0000, 4'd2, 1'b1, 1'b0);
    tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_full_ready got=%b want=0", in_ready); end
    drive(1'b1, 32'h33, 4'b0000, 4'd3, 1'b1, 1'b0);
    tick();
    n_cmp++; if (out_data !== 32'h11 || out_dst !== 4'd1 || out_valid !== 1'b1) begin n_err++; $display("FAIL stall_hold got=%h/%0d/%b want=11/1/1", out_data, out_dst, out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_hold_ready got=%b want=0", in_ready); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_data !== 32'h22 || out_dst !== 4'd2) begin n_err++; $display("FAIL stall_out_b got=%h/%0d want=22/2", out_data, out_dst); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_ready_rise got=%b want=1", in_ready); end
    tick();
    drive(1'b0, '0, 4'b0000, '0, 1'b0, 1'b0);
    n_cmp++; if (out_data !== 32'h33 || out_dst !== 4'd3 || out_valid !== 1'b1) begin n_err++; $display("FAIL stall_out_c got=%h/%0d/%b want=33/3/1", out_data, out_dst, out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_empty got=%b want=0", out_valid); end
  endtask

  task automatic test_forward();
    out_ready = 1'b0;
    fwd_idx = 4'd4;
    drive(1'b1, 32'hAAAA, 4'b0000, 4'd4, 1'b1, 1'b0);
    tick();
    n_cmp++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hAAAA) begin n_err++; $display("FAIL fwd_head got=%b/%h want=1/aaaa", fwd_hit, fwd_data); end
    drive(1'b1, 32'hBBBB, 4'b0000, 4'd4, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 4'b0000, '0, 1'b0, 1'b0);
    n_cmp++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hBBBB) begin n_err++; $display("FAIL fwd_skid_prio got=%b/%h want=1/bbbb", fwd_hit, fwd_data); end
    fwd_idx = 4'd5;
    #1;
    n_cmp++; if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin n_err++; $display("FAIL fwd_miss got=%b/%h want=0/0", fwd_hit, fwd_data); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    fwd_idx = 4'd4;
    #1;
    n_cmp++; if (fwd_hit !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL fwd_after_flush got=%b/%b want=0/0", fwd_hit, out_valid); end
    drive(1'b1, 32'hCCCC, 4'b0000, 4'd4, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 4'b0000, '0, 1'b0, 1'b0);
    n_cmp++; if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin n_err++; $display("FAIL fwd_no_we got=%b/%h want=0/0", fwd_hit, fwd_data); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h1, 4'b0011, 4'd1, 1'b1, 1'b1);
    tick();
    drive(1'b1, 32'h2, 4'b0110, 4'd2, 1'b1, 1'b0);
    tick();
    n_cmp++; if (flag_q !== 4'b0011 || in_ready !== 1'b0) begin n_err++; $display("FAIL flush_prefill got=%b/%b want=0011/0", flag_q, in_ready); end
    drive(1'b1, 32'h3, 4'b1000, 4'd3, 1'b1, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, 4'b0000, '0, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL flush_full got=%b/%b want=0/1", out_valid, in_ready); end
    n_cmp++; if (flag_q !== 4'b0011) begin n_err++; $display("FAIL flush_full_flag got=%b want=0011", flag_q); end
    // Flush while in_ready is high: the setf input in that cycle must be dropped
    drive(1'b1, 32'h4, 4'b0000, 4'd4, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h5, 4'b1111, 4'd5, 1'b1, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, 4'b0000, '0, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0 || flag_q !== 4'b0011) begin n_err++; $display("FAIL flush_one got=%b/%b want=0/0011", out_valid, flag_q); end
  endtask

  task automatic test_flags();
    out_ready = 1'b1;
    drive(1'b1, 32'hFFFF_FFFE, 4'b1100, 4'd6, 1'b1, 1'b1);
    tick();
    n_cmp++; if (flag_q !== 4'b1100) begin n_err++; $display("FAIL flags_sub got=%b want=1100", flag_q); end
    drive(1'b1, 32'h0, 4'b0000, 4'd7, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 4'b0000, '0, 1'b0, 1'b0);
    n_cmp++; if (flag_q !== 4'b1100) begin n_err++; $display("FAIL flags_and_nosetf got=%b want=1100", flag_q); end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + i, 4'b0000, 4'(i + 8), 1'b1, 1'b0);
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 32'h100 + i || out_dst !== 4'(i + 8) || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_%0d got=%b/%h/%0d/%b want=1/%h/%0d/1", i, out_valid, out_data, out_dst, in_ready, 32'h100 + i, i + 8);
      end
    end
    drive(1'b0, '0, 4'b0000, '0, 1'b0, 1'b0);
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'hA1, 4'b0101, 4'd1, 1'b1, 1'b1);
    tick();
    drive(1'b1, 32'hA2, 4'b0000, 4'd2, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 4'b0000, '0, 1'b0, 1'b0);
    n_cmp++; if (flag_q !== 4'b0101 || out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL arst_prefill got=%b/%b/%b want=0101/1/0", flag_q, out_valid, in_ready); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || flag_q !== 4'b0000 || in_ready !== 1'b0) begin n_err++; $display("FAIL arst_immediate got=%b/%b/%b want=0/0000/0", out_valid, flag_q, in_ready); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL arst_out_data got=%h want=0", out_data); end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL arst_release got=%b/%b want=1/0", in_ready, out_valid); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_stall();
    test_forward();
    test_flush();
    test_flags();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_ex_result_buffer.md
# cpu_ex_result_buffer

Two-entry result buffer and architectural flag register between the ALU and the write-back stage of the KH32 core. Captures the ALU result, ZCVN flags and destination tag through a valid/ready handshake and drains them in order to write-back. It holds the committed flag register and supplies operand forwarding back to the ALU inputs. Its 2-entry skid structure breaks the ready path so write-back stalls never combinationally reach the execute stage.

## Interface
- DATA_W, 32, result width (matches ALU result)
- REG_AW, 4, register-index width (16 architectural registers)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  execute stage presents a result
- in_ready  out  1  buffer can accept this cycle
- in_data  in  DATA_W  ALU result
- in_flag  in  4  ALU flags {Z,C,V,N}
- in_dst  in  REG_AW  destination register index
- in_we  in  1  instruction writes a register
- in_setf  in  1  instruction updates flags
- flush  in  1  discard all buffered and incoming results
- out_valid  out  1  head entry available to write-back
- out_ready  in  1  write-back consumes head
- out_data  out  DATA_W  head result
- out_dst  out  REG_AW  head destination
- out_we  out  1  head register-write enable
- flag_q  out  4  committed {Z,C,V,N}
- fwd_idx  in  REG_AW  register index requested by operand fetch
- fwd_hit  out  1  a buffered entry will write fwd_idx
- fwd_data  out  DATA_W  value from youngest matching entry, 0 if no hit

## Operation
- Two storage slots: HEAD drives out_*, SKID holds a second entry. Occupancy state: EMPTY, ONE, FULL.
- accept = in_valid & in_ready & !flush; pop = out_valid & out_ready & !flush.
- in_ready = (state != FULL) & !rst. It depends only on registered state, with no path from out_ready.
- Transitions:
  - EMPTY: accept -> ONE, HEAD loaded.
  - ONE: accept & !pop -> FULL, SKID loaded. accept & pop -> ONE, HEAD reloaded with input. pop only -> EMPTY.
  - FULL: pop -> ONE, HEAD <= SKID. Otherwise hold.
- flush: next state EMPTY; both slots invalidated; the input in the flush cycle is dropped. Flush wins over accept and pop in the same cycle.
- Flag register:
  - flag_q <= in_flag on accept & in_setf. Flags commit at acceptance, in program order.
  - Flush does not restore flag_q. A setf input in the flush cycle does not update it.
- out_valid = (state != EMPTY). out_we is meaningful only while out_valid.
- Forwarding, combinational:
  - Match = slot valid & slot we & slot dst == fwd_idx.
  - SKID (younger) has priority over HEAD.
  - fwd_data = 0 when fwd_hit = 0.
- Data and flag widths pass unmodified; no arithmetic is performed.

## Timing
- Reset (async assert, sync release): state EMPTY, out_valid 0, out_data 0, out_dst 0, out_we 0, flag_q 4'b0000, in_ready 0 while rst is high.
- Latency: an accepted entry appears on out_* the next cycle when the buffer was EMPTY or popped that cycle. Otherwise it appears after the older entry pops.
- Throughput: 1 entry/cycle sustained while out_ready = 1.
- in_ready falls the cycle after the buffer becomes FULL and rises the cycle after the first pop from FULL.
- flag_q is visible the cycle after the accepting edge.
- out_* are stable while out_valid & !out_ready. Order is strictly FIFO.
- Reset asserted mid-operation clears all state immediately; buffered entries are lost.

## Test plan
- Reset, then send data=0x0000_0005, flag=4'b0000, dst=3, we=1, setf=1 with out_ready=1 -> next cycle out_valid=1, out_data=0x5, out_dst=3, flag_q=0; following cycle out_valid=0.
- Stall out_ready=0, send A=0x11 (dst 1) then B=0x22 (dst 2) -> in_ready=0 after B; a third input C is held without loss. Raise out_ready -> outputs A, B, C on consecutive cycles, then out_valid=0.
- With A (dst 4, 0xAAAA) in HEAD and B (dst 4, 0xBBBB) in SKID, fwd_idx=4 -> fwd_hit=1, fwd_data=0xBBBB. fwd_idx=5 -> fwd_hit=0, fwd_data=0. An entry with we=0 and dst=4 alone -> fwd_hit=0.
- FULL buffer; assert flush together with in_valid (setf=1, flag=4'b1000) -> next cycle out_valid=0, in_ready=1, flag_q unchanged.
- Accept SUB with flag=4'b1100, setf=1, then AND with flag=4'b0000, setf=0 -> flag_q=4'b1100 after both.
- Assert rst asynchronously while FULL with flag_q=4'b0101 -> out_valid=0, flag_q=0, in_ready=0 before the next clock edge. After release, in_ready=1.
